ahb_lite_master: RTL

- Single-transfer AHB-Lite initiator.
- Converts a simple valid/ready command stream into pipelined AHB-Lite NONSEQ transfers, with the next address phase overlapping the current data phase.
- Returns one response per command, in order.
- Sits between on-chip requesters (DMA, debug, test engines) and the AHB-Lite interconnect that fronts the memory slaves.

---
 rtl/ahb_lite_master.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ahb_lite_master.sv
// Single-transfer AHB-Lite initiator: valid/ready commands become pipelined NONSEQ transfers, one in-order response each.
// Optional wait-state watchdog enabled by defining AHB_MASTER_TIMEOUT_EN.
module ahb_lite_master #(
    parameter int unsigned AHB_ADDR_WIDTH = 32,
    parameter int unsigned AHB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [AHB_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AHB_DATA_WIDTH-1:0] cmd_wdata,
    input  logic                      cmd_write,
    input  logic [2:0]                cmd_size,
    output logic                      rsp_valid,
    output logic [AHB_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    output logic                      bus_timeout,
    output logic [AHB_ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]                HTRANS,
    output logic                      HWRITE,
    output logic [2:0]                HSIZE,
    output logic [2:0]                HBURST,
    output logic [3:0]                HPROT,
    output logic                      HMASTLOCK,
    output logic [AHB_DATA_WIDTH-1:0] HWDATA,
    input  logic [AHB_DATA_WIDTH-1:0] HRDATA,
    input  logic                      HREADY,
    input  logic                      HRESP
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_ERR_WAIT   = 2'b01,
        ST_ERR_WAIT_C = 2'b10,
        ST_CANCEL_RSP = 2'b11
    } err_state_t;

    err_state_t                r_state;
    err_state_t                w_state_nxt;
    logic                      r_ap_valid;
    logic                      r_dp_valid;
    logic [AHB_ADDR_WIDTH-1:0] r_haddr;
    logic                      r_hwrite;
    logic [2:0]                r_hsize;
    logic [AHB_DATA_WIDTH-1:0] r_ap_wdata;
    logic [AHB_DATA_WIDTH-1:0] r_hwdata;

    logic                      w_to_hit;
    logic                      w_bus_timeout;
    logic                      w_err_hold;
    logic                      w_cmd_ready;
    logic                      w_accept;
    logic                      w_err_c1;
    logic                      w_cancel;
    logic                      w_reg_rsp;
    logic                      w_rsp_valid;
    logic                      w_rsp_err;
    logic [AHB_DATA_WIDTH-1:0] w_rsp_rdata;

`ifdef AHB_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_to_cnt;
    logic             r_bus_timeout;

    assign w_to_hit = r_dp_valid & ~HREADY & ~r_bus_timeout &
                      (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_bus_timeout = r_bus_timeout;

    // Consecutive wait-state counter and sticky timeout flag.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_to_cnt      <= '0;
            r_bus_timeout <= 1'b0;
        end else if (w_to_hit) begin
            r_to_cnt      <= '0;
            r_bus_timeout <= 1'b1;
        end else if (HREADY) begin
            r_to_cnt      <= '0;
        end else if (r_dp_valid) begin
            r_to_cnt      <= r_to_cnt + CNT_W'(1);
        end else begin
            r_to_cnt      <= r_to_cnt;
        end
    end
`else
    logic [31:0] w_unused_timeout_cycles;

    assign w_unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign w_to_hit      = 1'b0;
    assign w_bus_timeout = 1'b0;
`endif

    assign w_err_hold  = (r_state != ST_IDLE);
    assign w_cmd_ready = HREADY & ~w_err_hold & ~w_bus_timeout & ~HRESET;
    assign w_accept    = cmd_valid & w_cmd_ready;
    // First cycle of a two-cycle ERROR; a queued address phase must be withdrawn.
    assign w_err_c1    = r_dp_valid & ~HREADY & HRESP & (r_state == ST_IDLE) & ~w_to_hit;
    assign w_cancel    = w_err_c1 & r_ap_valid;

    // Error-sequence state register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Error-sequence next state; a timeout overrides any sequence in progress.
    always_comb begin
        w_state_nxt = r_state;
        if (w_to_hit) begin
            w_state_nxt = (r_ap_valid || (r_state == ST_ERR_WAIT_C)) ? ST_CANCEL_RSP : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:       w_state_nxt = w_err_c1 ? (r_ap_valid ? ST_ERR_WAIT_C : ST_ERR_WAIT)
                                                      : ST_IDLE;
                ST_ERR_WAIT:   w_state_nxt = HREADY ? ST_IDLE : ST_ERR_WAIT;
                ST_ERR_WAIT_C: w_state_nxt = HREADY ? ST_CANCEL_RSP : ST_ERR_WAIT_C;
                ST_CANCEL_RSP: w_state_nxt = ST_IDLE;
                default:       w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Address/data pipeline; only advances on HREADY edges.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_ap_valid <= 1'b0;
            r_dp_valid <= 1'b0;
            r_haddr    <= '0;
            r_hwrite   <= 1'b0;
            r_hsize    <= 3'b000;
            r_ap_wdata <= '0;
            r_hwdata   <= '0;
        end else if (w_to_hit) begin
            r_ap_valid <= 1'b0;
            r_dp_valid <= 1'b0;
        end else if (HREADY) begin
            r_dp_valid <= r_ap_valid;
            if (r_ap_valid) begin
                r_hwdata <= r_ap_wdata;
            end
            if (w_accept) begin
                r_ap_valid <= 1'b1;
                r_haddr    <= cmd_addr;
                r_hwrite   <= cmd_write;
                r_hsize    <= cmd_size;
                r_ap_wdata <= cmd_wdata;
            end else begin
                r_ap_valid <= 1'b0;
            end
        end else if (w_cancel) begin
            r_ap_valid <= 1'b0;
        end
    end

    // Response mux: live data-phase completion, or the registered cancel/timeout response.
    always_comb begin
        w_reg_rsp   = (r_state == ST_CANCEL_RSP);
        w_rsp_valid = ~HRESET & (w_reg_rsp | (r_dp_valid & (HREADY | w_to_hit)));
        if (w_reg_rsp) begin
            w_rsp_err   = ~HRESET;
            w_rsp_rdata = '0;
        end else begin
            w_rsp_err   = w_rsp_valid & (HRESP | w_to_hit);
            w_rsp_rdata = HRDATA;
        end
    end

    assign cmd_ready   = w_cmd_ready;
    assign rsp_valid   = w_rsp_valid;
    assign rsp_err     = w_rsp_err;
    assign rsp_rdata   = w_rsp_rdata;
    assign bus_timeout = w_bus_timeout;
    assign HADDR       = r_haddr;
    assign HTRANS      = r_ap_valid ? 2'b10 : 2'b00;
    assign HWRITE      = r_hwrite;
    assign HSIZE       = r_hsize;
    assign HWDATA      = r_hwdata;
    assign HBURST      = 3'b000;
    assign HPROT       = 4'b0011;
    assign HMASTLOCK   = 1'b0;

endmodule
